tara_estabilizador: RTL and testbench
=====================================

# tara_estabilizador

Upstream stage of the scale datapath, sitting between the load-cell sample source and `multiplicador`. Each valid raw weight sample is checked for stability, the tare is stored on a button request, and `quilos_tara` (net weight, saturated at zero) is delivered to the price multiplier. Tare capture happens only on a stable reading; a request made while the weight is moving stays pending until the weight settles.

## Interface
- `W_PESO`, 12: width of raw weight, tare and net weight (matches `multiplicador.quilos_tara`).
- `N_ESTAVEL`, 8: consecutive in-tolerance samples required to declare the weight stable (≥2).
- `TOL`, 2: maximum absolute deviation (LSB) from the run reference that still counts as in-tolerance.

- `clk`  in  1  single system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `amostra_valida`  in  1  one-cycle strobe: `peso` is a new sample.
- `peso`  in  W_PESO  raw unsigned weight; sampled only when `amostra_valida`=1.
- `botao_tara`  in  1  tare button, already synchronised/debounced; a rising edge is a request.
- `botao_limpa`  in  1  clear-tare level; while high, tare is forced to 0.
- `quilos_tara`  out  W_PESO  net weight, registered.
- `tara`  out  W_PESO  stored tare, registered.
- `estavel`  out  1  weight stable flag, registered.
- `negativo`  out  1  last sample below tare (net clamped to 0).
- `tara_pendente`  out  1  tare request waiting for stability.
- `valido`  out  1  one-cycle pulse: outputs updated from a new sample.

## Operation
- Reset values: all outputs 0. Internal `peso_ref`=0, `cont`=0, button-edge register=0, FSM = `S_INSTAVEL`.
- Edge detect: `pedido` = `botao_tara` & ~registered `botao_tara`. The register updates every cycle, not only on samples.
- Stability, evaluated only on `amostra_valida`:
  - if |`peso` − `peso_ref`| ≤ `TOL`: `cont` ← min(`cont`+1, `N_ESTAVEL`).
  - otherwise: `peso_ref` ← `peso`, `cont` ← 1.
  - `estavel` = (`cont` ≥ `N_ESTAVEL`), using the updated `cont`.
  - The difference is computed at W_PESO+1 bits. No wrap-around.
- FSM:
  - `S_INSTAVEL` → `S_ESTAVEL` when `estavel` becomes true. `S_ESTAVEL` → `S_INSTAVEL` on an out-of-tolerance sample.
  - Either state → `S_TARA_PEND` on `pedido` when not stable.
  - `S_TARA_PEND` → `S_ESTAVEL` on the sample that makes the weight stable; that sample is captured as tare.
  - `pedido` in `S_ESTAVEL` captures tare on the next valid sample. If that sample breaks stability, the request goes to `S_TARA_PEND`.
  - `tara_pendente` = (state == `S_TARA_PEND`).
- Tare update, in priority order:
  1. `botao_limpa`=1: `tara` ← 0, pending cleared, FSM goes to `S_INSTAVEL` or `S_ESTAVEL` according to `estavel`. This applies every cycle, sample or not.
  2. Capture: `tara` ← `peso`.
- Net weight, on each sample, using the post-update tare of that same cycle:
  - `quilos_tara` ← `peso` ≥ `tara` ? `peso` − `tara` : 0.
  - `negativo` ← (`peso` < `tara`).
  - A capture sample therefore yields `quilos_tara`=0.
- Repeated `pedido` while pending is absorbed; there is no queue.

## Timing
- Latency 1: for a sample at edge k, all outputs are updated at edge k, and `valido`=1 for exactly the cycle following edge k.
- `estavel` rises at the earliest on the `N_ESTAVEL`-th in-tolerance sample of a run, counting the reference sample.
- `pedido` and `amostra_valida` in the same cycle: the request applies to that sample.
- `botao_limpa` and a capture in the same cycle: clear wins and the request is dropped.
- Back-to-back `amostra_valida` (every cycle) is supported at full rate.
- Reset mid-run: everything returns to reset values asynchronously. The first sample after reset starts a new run with `cont`=1 unless it is within `TOL` of 0.

## Structure
- Shared package `balanca_pkg`:
  - FSM state typedef (`S_INSTAVEL`, `S_ESTAVEL`, `S_TARA_PEND`).
  - Default `W_PESO`, which is also used by `multiplicador`.
- Sub-module `detetor_estabilidade`:
  - Owns `peso_ref` and `cont`.
  - Outputs `estavel` and `fora_tol`.
- The top level holds the button edge detect, the FSM, the tare register and the subtract/clamp.

## Test plan
- Feed `peso`=500 for 8 samples → `estavel`=1 after the 8th; `quilos_tara`=500 on each sample.
- Apply `pedido` while stable at 500, then a sample of 501 → `tara`=501, `quilos_tara`=0; next sample 800 (unstable) → `quilos_tara`=299.
- Apply `pedido` with samples alternating 100/120 → `tara_pendente`=1 and `tara` unchanged; then 8 samples of 300 → `tara`=300 on the 8th, `tara_pendente`=0.
- With `tara`=300, send `peso`=250 → `quilos_tara`=0, `negativo`=1; then `botao_limpa` pulse and sample 250 → `tara`=0, `quilos_tara`=250.
- `botao_limpa` and `pedido` in the same cycle while stable → `tara`=0 and no capture occurs.
- Assert `rst_n` low mid-pending → all outputs 0 immediately; `estavel` reappears only after `N_ESTAVEL` new samples.

Source files
------------

// File: rtl/balanca_pkg.sv
// Types and defaults shared by the scale datapath (tare/stability stage and multiplier).
package balanca_pkg;

   localparam int W_PESO_PADRAO = 12;

   typedef enum logic [1:0] {
      S_INSTAVEL  = 2'd0,
      S_ESTAVEL   = 2'd1,
      S_TARA_PEND = 2'd2
   } estado_t;

endpackage

// File: rtl/detetor_estabilidade.sv
// Tracks a run of samples that stay within TOL of the run's first sample and
// flags the weight as stable once the run reaches N_ESTAVEL samples.
module detetor_estabilidade
   import balanca_pkg::*;
#(
   parameter int W_PESO    = W_PESO_PADRAO,
   parameter int N_ESTAVEL = 8,
   parameter int TOL       = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              amostra_valida,
   input  logic [W_PESO-1:0] peso,
   output logic              estavel,
   output logic              fora_tol
);

   localparam int CW = $clog2(N_ESTAVEL + 1);
   localparam logic [CW-1:0] CONT_MAX = CW'(N_ESTAVEL);
   localparam logic [W_PESO:0] TOL_W = (W_PESO + 1)'(TOL);
   localparam logic [W_PESO:0] UM_W  = (W_PESO + 1)'(1);

   logic [W_PESO-1:0] peso_ref;
   logic [CW-1:0]     cont;
   logic [CW-1:0]     cont_nxt;
   logic [W_PESO:0]   dif;
   logic [W_PESO:0]   dif_abs;

   // One extra bit keeps the sign, so 0 vs full-scale never wraps into tolerance.
   assign dif     = {1'b0, peso} - {1'b0, peso_ref};
   assign dif_abs = dif[W_PESO] ? (~dif + UM_W) : dif;

   always_comb begin
      fora_tol = 1'b0;
      cont_nxt = cont;
      if (amostra_valida) begin
         if (dif_abs <= TOL_W) begin
            cont_nxt = (cont >= CONT_MAX) ? CONT_MAX : cont + CW'(1);
         end else begin
            fora_tol = 1'b1;
            cont_nxt = CW'(1);
         end
      end
   end

   // Reflects the count after this cycle's sample, so the top can act on it immediately.
   assign estavel = (cont_nxt >= CONT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peso_ref <= '0;
         cont     <= '0;
      end else begin
         cont <= cont_nxt;
         if (fora_tol) begin
            peso_ref <= peso;
         end
      end
   end

endmodule

// File: rtl/tara_estabilizador.sv
// Stability-gated tare capture and net-weight (clamped at zero) generation
// ahead of the price multiplier.
module tara_estabilizador
   import balanca_pkg::*;
#(
   parameter int W_PESO    = W_PESO_PADRAO,
   parameter int N_ESTAVEL = 8,
   parameter int TOL       = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              amostra_valida,
   input  logic [W_PESO-1:0] peso,
   input  logic              botao_tara,
   input  logic              botao_limpa,
   output logic [W_PESO-1:0] quilos_tara,
   output logic [W_PESO-1:0] tara,
   output logic              estavel,
   output logic              negativo,
   output logic              tara_pendente,
   output logic              valido,
   output logic [1:0]        estado_dbg
);

   // Handshake: amostra_valida is a one-cycle strobe with no back-pressure; every
   // strobed sample is consumed at that edge and answered by a one-cycle valido.

   estado_t           estado;
   logic              botao_q;
   logic              pedido;
   logic              est_n;
   logic              fora_tol;
   logic              armado;
   logic              captura;
   logic [W_PESO-1:0] tara_nxt;

   assign pedido     = botao_tara & ~botao_q;
   assign estado_dbg = estado;

   detetor_estabilidade #(
      .W_PESO   (W_PESO),
      .N_ESTAVEL(N_ESTAVEL),
      .TOL      (TOL)
   ) u_detetor (
      .clk           (clk),
      .rst_n         (rst_n),
      .amostra_valida(amostra_valida),
      .peso          (peso),
      .estavel       (est_n),
      .fora_tol      (fora_tol)
   );

   // armado holds a request made while stable until the next sample decides it.
   always_comb begin
      captura = 1'b0;
      if (!botao_limpa && amostra_valida && est_n) begin
         case (estado)
            S_INSTAVEL:  captura = pedido;
            S_ESTAVEL:   captura = pedido | armado;
            S_TARA_PEND: captura = 1'b1;
            default:     captura = 1'b0;
         endcase
      end
   end

   always_comb begin
      tara_nxt = tara;
      if (botao_limpa) begin
         tara_nxt = '0;
      end else if (captura) begin
         tara_nxt = peso;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado        <= S_INSTAVEL;
         botao_q       <= 1'b0;
         armado        <= 1'b0;
         tara          <= '0;
         quilos_tara   <= '0;
         estavel       <= 1'b0;
         negativo      <= 1'b0;
         tara_pendente <= 1'b0;
         valido        <= 1'b0;
      end else begin
         botao_q <= botao_tara;
         estavel <= est_n;
         valido  <= amostra_valida;
         tara    <= tara_nxt;
         // Net weight uses the tare as updated in this same cycle.
         if (amostra_valida) begin
            quilos_tara <= (peso >= tara_nxt) ? (peso - tara_nxt) : '0;
            negativo    <= (peso < tara_nxt);
         end
         if (botao_limpa) begin
            armado        <= 1'b0;
            tara_pendente <= 1'b0;
            estado        <= est_n ? S_ESTAVEL : S_INSTAVEL;
         end else begin
            case (estado)
               S_INSTAVEL: begin
                  if (pedido && !captura) begin
                     estado        <= S_TARA_PEND;
                     tara_pendente <= 1'b1;
                  end else if (est_n) begin
                     estado <= S_ESTAVEL;
                  end
               end
               S_ESTAVEL: begin
                  if (amostra_valida) begin
                     armado <= 1'b0;
                     if (fora_tol || !est_n) begin
                        if (pedido || armado) begin
                           estado        <= S_TARA_PEND;
                           tara_pendente <= 1'b1;
                        end else begin
                           estado <= S_INSTAVEL;
                        end
                     end
                  end else if (pedido) begin
                     armado <= 1'b1;
                  end
               end
               S_TARA_PEND: begin
                  if (captura) begin
                     estado        <= S_ESTAVEL;
                     tara_pendente <= 1'b0;
                  end
               end
               default: begin
                  estado        <= S_INSTAVEL;
                  armado        <= 1'b0;
                  tara_pendente <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tara_estabilizador.sv
// Directed plus randomized bench for tara_estabilizador against a run/tare reference model.
module tb_tara_estabilizador;
   import balanca_pkg::*;

   localparam int W = 12;
   localparam int N = 8;
   localparam int T = 2;
   localparam int PMAX = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         amostra_valida = 1'b0;
   logic [W-1:0] peso = '0;
   logic         botao_tara = 1'b0;
   logic         botao_limpa = 1'b0;
   logic [W-1:0] quilos_tara;
   logic [W-1:0] tara;
   logic         estavel;
   logic         negativo;
   logic         tara_pendente;
   logic         valido;
   logic [1:0]   estado_dbg;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_ref, m_run, m_tara, m_quilos, m_neg, m_pend, m_arm, m_est, m_val, m_bt_prev;

   tara_estabilizador #(.W_PESO(W), .N_ESTAVEL(N), .TOL(T)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .amostra_valida(amostra_valida),
      .peso          (peso),
      .botao_tara    (botao_tara),
      .botao_limpa   (botao_limpa),
      .quilos_tara   (quilos_tara),
      .tara          (tara),
      .estavel       (estavel),
      .negativo      (negativo),
      .tara_pendente (tara_pendente),
      .valido        (valido),
      .estado_dbg    (estado_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelo_reset();
      m_ref = 0; m_run = 0; m_tara = 0; m_quilos = 0; m_neg = 0;
      m_pend = 0; m_arm = 0; m_est = 0; m_val = 0; m_bt_prev = 0;
   endtask

   task automatic modelo_passo(input int av, input int p, input int bt, input int bl);
      int ped, quer, d;
      ped = (bt != 0 && m_bt_prev == 0) ? 1 : 0;
      m_bt_prev = bt;
      if (av != 0) begin
         d = p - m_ref;
         if (d < 0) d = -d;
         if (d <= T) m_run = m_run + 1;
         else begin
            m_ref = p;
            m_run = 1;
         end
      end
      if (bl != 0) begin
         m_tara = 0; m_pend = 0; m_arm = 0;
      end else begin
         quer = (ped != 0 || m_arm != 0 || m_pend != 0) ? 1 : 0;
         if (av != 0 && quer != 0) begin
            if (m_run >= N) begin
               m_tara = p; m_pend = 0;
            end else begin
               m_pend = 1;
            end
            m_arm = 0;
         end else if (av == 0 && ped != 0) begin
            if (m_est != 0) m_arm = 1;
            else m_pend = 1;
         end
      end
      if (av != 0) begin
         m_quilos = (p >= m_tara) ? p - m_tara : 0;
         m_neg = (p < m_tara) ? 1 : 0;
      end
      m_val = av;
      m_est = (m_run >= N) ? 1 : 0;
   endtask

   task automatic confere(input string ctx);
      chk({ctx, "/quilos_tara"}, 32'(quilos_tara), 32'(m_quilos));
      chk({ctx, "/tara"}, 32'(tara), 32'(m_tara));
      chk({ctx, "/estavel"}, 32'(estavel), 32'(m_est));
      chk({ctx, "/negativo"}, 32'(negativo), 32'(m_neg));
      chk({ctx, "/tara_pendente"}, 32'(tara_pendente), 32'(m_pend));
      chk({ctx, "/valido"}, 32'(valido), 32'(m_val));
   endtask

   task automatic ciclo(input int av, input int p, input int bt, input int bl, input string ctx);
      amostra_valida = (av != 0);
      peso = p[W-1:0];
      botao_tara = (bt != 0);
      botao_limpa = (bl != 0);
      @(posedge clk);
      #1;
      modelo_passo(av, p, bt, bl);
      confere(ctx);
   endtask

   initial begin
      int base, p;
      modelo_reset();
      #2;
      confere("reset");
      chk("reset/estado", 32'(estado_dbg), 32'(S_INSTAVEL));
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // stable at 500 after the 8th sample
      for (int i = 0; i < N; i++) ciclo(1, 500, 0, 0, "tp1");
      chk("tp1/estavel8", 32'(estavel), 32'd1);
      chk("tp1/quilos500", 32'(quilos_tara), 32'd500);

      // request while stable, captured on next in-tolerance sample
      ciclo(0, 0, 1, 0, "tp2_pedido");
      ciclo(1, 501, 0, 0, "tp2_captura");
      chk("tp2/tara501", 32'(tara), 32'd501);
      chk("tp2/quilos0", 32'(quilos_tara), 32'd0);
      ciclo(1, 800, 0, 0, "tp2_800");
      chk("tp2/quilos299", 32'(quilos_tara), 32'd299);

      // request while moving stays pending; repeated request absorbed
      ciclo(0, 0, 1, 0, "tp3_pedido");
      ciclo(1, 100, 0, 0, "tp3_alt");
      ciclo(1, 120, 1, 0, "tp3_alt");
      ciclo(1, 100, 0, 0, "tp3_alt");
      ciclo(1, 120, 0, 0, "tp3_alt");
      chk("tp3/pendente", 32'(tara_pendente), 32'd1);
      chk("tp3/tara_mantida", 32'(tara), 32'd501);
      for (int i = 0; i < N - 1; i++) ciclo(1, 300, 0, 0, "tp3_300");
      chk("tp3/ainda_pendente", 32'(tara_pendente), 32'd1);
      ciclo(1, 300, 0, 0, "tp3_300_ultimo");
      chk("tp3/tara300", 32'(tara), 32'd300);
      chk("tp3/pendente0", 32'(tara_pendente), 32'd0);

      // below tare, then clear
      ciclo(1, 250, 0, 0, "tp4_250");
      chk("tp4/negativo", 32'(negativo), 32'd1);
      chk("tp4/quilos0", 32'(quilos_tara), 32'd0);
      ciclo(0, 0, 0, 1, "tp4_limpa");
      ciclo(1, 250, 0, 0, "tp4_250b");
      chk("tp4/quilos250", 32'(quilos_tara), 32'd250);

      // clear and request together: clear wins, no later capture
      for (int i = 0; i < N; i++) ciclo(1, 700, 0, 0, "tp5_700");
      ciclo(1, 700, 1, 1, "tp5_limpa_pedido");
      ciclo(1, 701, 0, 0, "tp5_sem_captura");
      chk("tp5/tara0", 32'(tara), 32'd0);
      ciclo(0, 0, 1, 1, "tp5_limpa_pedido_b");
      ciclo(1, 700, 0, 0, "tp5_sem_captura_b");
      chk("tp5/tara0_b", 32'(tara), 32'd0);

      // request on a sample that breaks stability goes pending
      ciclo(1, 900, 1, 0, "tp6_quebra");
      chk("tp6/pendente", 32'(tara_pendente), 32'd1);
      ciclo(0, 0, 0, 1, "tp6_limpa");

      // tolerance edges and full-scale wrap
      ciclo(1, 1000, 0, 0, "tol");
      ciclo(1, 1002, 0, 0, "tol");
      ciclo(1, 998, 0, 0, "tol");
      ciclo(1, 1002, 0, 0, "tol");
      ciclo(1, 998, 0, 0, "tol");
      ciclo(1, 1001, 0, 0, "tol");
      ciclo(1, 999, 0, 0, "tol");
      ciclo(1, 1000, 0, 0, "tol");
      chk("tol/estavel", 32'(estavel), 32'd1);
      ciclo(1, 1003, 0, 0, "tol_fora");
      chk("tol/instavel", 32'(estavel), 32'd0);
      for (int i = 0; i < N; i++) ciclo(1, PMAX, 0, 0, "max");
      ciclo(1, 0, 0, 0, "wrap");
      chk("wrap/instavel", 32'(estavel), 32'd0);

      // asynchronous reset while pending
      ciclo(1, 50, 0, 0, "rst_pre");
      ciclo(1, 60, 1, 0, "rst_pend");
      amostra_valida = 1'b0;
      botao_tara = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      modelo_reset();
      confere("rst_mid");
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < N - 1; i++) ciclo(1, 2, 0, 0, "pos_rst");
      chk("pos_rst/estavel7", 32'(estavel), 32'd0);
      ciclo(1, 2, 0, 0, "pos_rst8");
      chk("pos_rst/estavel8", 32'(estavel), 32'd1);

      // randomized traffic
      base = 400;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            case ($urandom_range(0, 3))
               0: base = 0;
               1: base = PMAX;
               default: base = int'($urandom_range(0, PMAX));
            endcase
         end
         p = base + int'($urandom_range(0, 6)) - 3;
         if (p < 0) p = 0;
         if (p > PMAX) p = PMAX;
         ciclo(($urandom_range(0, 3) != 0) ? 1 : 0, p,
               ($urandom_range(0, 7) == 0) ? 1 : 0,
               ($urandom_range(0, 39) == 0) ? 1 : 0, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
